// File: rtl/timestamp_decoder.sv
// Reassembles 64-bit timestamps from the three-word FIFO stream of the capture block.
// Checks identifier and word order, and hands events over on a valid/ready port.
module timestamp_decoder #(
    parameter logic [3:0] IDENTIFIER    = 4'b0101,
    parameter int         ERR_CNT_WIDTH = 8,
    parameter int         EVT_CNT_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     FIFO_EMPTY,
    input  logic [31:0]              FIFO_DATA,
    output logic                     FIFO_READ,
    output logic [63:0]              TS_DATA,
    output logic                     TS_VALID,
    input  logic                     TS_READY,
    input  logic                     CLR,
    output logic [ERR_CNT_WIDTH-1:0] ERR_CNT,
    output logic [EVT_CNT_WIDTH-1:0] EVT_CNT
);

    typedef enum logic [1:0] {
        EXP0,
        EXP1,
        EXP2,
        OUT
    } state_t;

    state_t                   state_q, state_d;
    logic [63:0]              ts_q, ts_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
    logic [EVT_CNT_WIDTH-1:0] evt_q, evt_d;
    logic                     err_inc;
    logic                     evt_inc;
    logic                     id_ok;
    logic [3:0]               idx;
    logic [23:0]              pl;

    assign id_ok     = (FIFO_DATA[31:28] == IDENTIFIER);
    assign idx       = FIFO_DATA[27:24];
    assign pl        = FIFO_DATA[23:0];
    assign FIFO_READ = !FIFO_EMPTY && (state_q != OUT);
    assign TS_VALID  = (state_q == OUT);
    assign TS_DATA   = ts_q;
    assign ERR_CNT   = err_q;
    assign EVT_CNT   = evt_q;

    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        err_inc = 1'b0;
        evt_inc = 1'b0;
        unique case (state_q)
            EXP0: begin
                if (FIFO_READ) begin
                    if (id_ok && idx == 4'd0) begin
                        ts_d[23:0] = pl;
                        state_d    = EXP1;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            EXP1: begin
                if (FIFO_READ) begin
                    if (id_ok && idx == 4'd1) begin
                        ts_d[47:24] = pl;
                        state_d     = EXP2;
                    end else if (id_ok && idx == 4'd0) begin
                        err_inc    = 1'b1;
                        ts_d[23:0] = pl;
                        state_d    = EXP1;
                    end else begin
                        err_inc = 1'b1;
                        state_d = EXP0;
                    end
                end
            end
            EXP2: begin
                if (FIFO_READ) begin
                    if (id_ok && idx == 4'd2) begin
                        ts_d[63:48] = pl[15:0];
                        state_d     = OUT;
                    end else if (id_ok && idx == 4'd0) begin
                        // A fresh word 0 restarts the event rather than dropping it
                        err_inc    = 1'b1;
                        ts_d[23:0] = pl;
                        state_d    = EXP1;
                    end else begin
                        err_inc = 1'b1;
                        state_d = EXP0;
                    end
                end
            end
            OUT: begin
                if (TS_READY) begin
                    evt_inc = 1'b1;
                    state_d = EXP0;
                end
            end
            default: state_d = EXP0;
        endcase
    end

    always_comb begin
        err_d = err_q;
        evt_d = evt_q;
        if (CLR) begin
            err_d = '0;
            evt_d = '0;
        end else begin
            if (err_inc && err_q != '1) err_d = err_q + 1'b1;
            if (evt_inc) evt_d = evt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= EXP0;
            ts_q    <= '0;
            err_q   <= '0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            err_q   <= err_d;
            evt_q   <= evt_d;
        end
    end

endmodule

// File: tb/tb_timestamp_decoder.sv
// Directed bench for timestamp_decoder: FIFO model feeding words,
// scoreboard of expected timestamps checked at each output handshake.
module tb_timestamp_decoder;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        FIFO_EMPTY = 1'b1;
    logic [31:0] FIFO_DATA = '0;
    logic        FIFO_READ;
    logic [63:0] TS_DATA;
    logic        TS_VALID;
    logic        TS_READY = 1'b0;
    logic        CLR = 1'b0;
    logic [7:0]  ERR_CNT;
    logic [15:0] EVT_CNT;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_pop_cyc = -100;
    logic        rd_s = 1'b0;
    logic        valid_prev = 1'b0;
    logic [31:0] fifo[$];
    logic [63:0] sb[$];

    timestamp_decoder dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_DATA (FIFO_DATA),
        .FIFO_READ (FIFO_READ),
        .TS_DATA   (TS_DATA),
        .TS_VALID  (TS_VALID),
        .TS_READY  (TS_READY),
        .CLR       (CLR),
        .ERR_CNT   (ERR_CNT),
        .EVT_CNT   (EVT_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fifo_upd();
        FIFO_EMPTY = (fifo.size() == 0);
        FIFO_DATA  = (fifo.size() == 0) ? 32'h0 : fifo[0];
    endtask

    task automatic push(input logic [31:0] w);
        fifo.push_back(w);
        fifo_upd();
    endtask

    always @(posedge CLK) cyc++;

    always @(negedge CLK) rd_s = FIFO_READ;

    // FIFO model: consume the head word one step after the popping edge
    always @(posedge CLK) begin
        if (rd_s && RST_N) begin
            #1;
            if (fifo.size() != 0) void'(fifo.pop_front());
            last_pop_cyc = cyc;
            fifo_upd();
        end
    end

    always @(negedge CLK) begin
        if (!RST_N) begin
            valid_prev = 1'b0;
        end else begin
            if (TS_VALID && !valid_prev)
                chk("latency", 64'(cyc), 64'(last_pop_cyc));
            valid_prev = TS_VALID;
            if (TS_VALID && TS_READY) begin
                if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
                else chk("ts_data", TS_DATA, sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_evt(input logic [15:0] n, input int lim);
        int k;
        k = 0;
        while (EVT_CNT !== n && k < lim) begin
            @(negedge CLK);
            k++;
        end
        chk("evt_cnt", 64'(EVT_CNT), 64'(n));
    endtask

    task automatic wait_empty(input int lim);
        int k;
        k = 0;
        while (fifo.size() != 0 && k < lim) begin
            @(negedge CLK);
            k++;
        end
        chk("fifo_drain", 64'(fifo.size()), 64'd0);
        @(negedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        #12;
        chk("rst_valid", 64'(TS_VALID), 64'd0);
        chk("rst_read", 64'(FIFO_READ), 64'd0);
        chk("rst_ts", TS_DATA, 64'd0);
        chk("rst_err", 64'(ERR_CNT), 64'd0);
        chk("rst_evt", 64'(EVT_CNT), 64'd0);
        step();
        RST_N = 1'b1;
        step();

        TS_READY = 1'b1;
        sb.push_back(64'h7788123456ABCDEF);
        push(32'h50ABCDEF);
        push(32'h51123456);
        push(32'h52FF7788);
        wait_evt(16'd1, 30);

        TS_READY = 1'b0;
        sb.push_back(64'h3333222222111111);
        push(32'h50111111);
        push(32'h51222222);
        push(32'h52003333);
        sb.push_back(64'h0030000020000010);
        push(32'h50000010);
        push(32'h51000020);
        push(32'h52000030);
        for (int k = 0; k < 30 && TS_VALID !== 1'b1; k++) @(negedge CLK);
        chk("hold_valid", 64'(TS_VALID), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("hold_read", 64'(FIFO_READ), 64'd0);
            chk("hold_ts", TS_DATA, 64'h3333222222111111);
        end
        step();
        TS_READY = 1'b1;
        wait_evt(16'd3, 40);

        sb.push_back(64'h0000000000000002);
        push(32'h50000001);
        push(32'h50000002);
        push(32'h51000000);
        push(32'h52000000);
        wait_evt(16'd4, 40);
        chk("seq_err", 64'(ERR_CNT), 64'd1);

        step();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        @(negedge CLK);
        chk("clr_err", 64'(ERR_CNT), 64'd0);
        chk("clr_evt", 64'(EVT_CNT), 64'd0);
        step();
        push(32'h50000AAA);
        push(32'h30000000);
        sb.push_back(64'h0789000456000123);
        push(32'h50000123);
        push(32'h51000456);
        push(32'h52000789);
        wait_evt(16'd1, 40);
        chk("id_err", 64'(ERR_CNT), 64'd1);

        step();
        for (int i = 0; i < 300; i++) push(32'h70000000);
        wait_empty(400);
        chk("err_sat", 64'(ERR_CNT), 64'd255);
        step();
        push(32'h7000BEEF);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        @(negedge CLK);
        chk("clr_prio", 64'(ERR_CNT), 64'd0);
        chk("clr_pop", 64'(fifo.size()), 64'd0);

        step();
        push(32'h50000777);
        push(32'h51000888);
        wait_empty(20);
        #3;
        RST_N = 1'b0;
        #1;
        chk("arst_valid", 64'(TS_VALID), 64'd0);
        chk("arst_read", 64'(FIFO_READ), 64'd0);
        chk("arst_ts", TS_DATA, 64'd0);
        chk("arst_evt", 64'(EVT_CNT), 64'd0);
        step();
        step();
        RST_N = 1'b1;
        step();
        sb.push_back(64'h1234BEEF00C0FFEE);
        push(32'h50C0FFEE);
        push(32'h51BEEF00);
        push(32'h52AA1234);
        wait_evt(16'd1, 30);
        chk("arst_err", 64'(ERR_CNT), 64'd0);
        chk("sb_left", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timestamp_decoder.md
Name: timestamp_decoder

Overview:
- Reader-side counterpart of the timestamp capture block.
- Pops the 32-bit word stream that the capture block writes into its FIFO, checks each word's identifier and word index, and reassembles a 64-bit timestamp.
- Presents each reassembled timestamp on a valid/ready output, with error and event counters.
- Sits between a FIFO read port and a downstream consumer (trigger logic or a checker in simulation).

Parameters:
- IDENTIFIER, 4'b0101, value expected in word bits [31:28]; any other value is an identifier error.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.
- EVT_CNT_WIDTH, 16, width of the wrapping event counter.

Ports:
- CLK  input  1  single clock for the whole block.
- RST_N  input  1  asynchronous, active-low reset.
- FIFO_EMPTY  input  1  source FIFO empty; FIFO_DATA is valid whenever this is low (first-word-fall-through).
- FIFO_DATA  input  32  head word of the source FIFO.
- FIFO_READ  output  1  pop strobe; the word is consumed in the cycle this is high.
- TS_DATA  output  64  reassembled timestamp.
- TS_VALID  output  1  TS_DATA holds a complete event.
- TS_READY  input  1  consumer accepts TS_DATA.
- CLR  input  1  synchronous clear of both counters.
- ERR_CNT  output  ERR_CNT_WIDTH  identifier and sequence errors; saturates at all-ones.
- EVT_CNT  output  EVT_CNT_WIDTH  completed events handed over; wraps to 0.

Behaviour:
- Interface: one clock, CLK; reset is asynchronous and active-low, RST_N.
- Word format (fixed):
  - [31:28] identifier.
  - [27:24] word index.
  - [23:0] payload.
  - Index 0: payload = TS[23:0]. Index 1: payload = TS[47:24]. Index 2: payload[15:0] = TS[63:48]; payload[23:16] ignored.
- Reset: state EXP0; TS_DATA=0, TS_VALID=0, FIFO_READ=0, ERR_CNT=0, EVT_CNT=0. Reset during any state discards partial and pending events.
- FIFO_READ = !FIFO_EMPTY && state in {EXP0, EXP1, EXP2}. It is combinational from state and FIFO_EMPTY, so it is never high in state OUT.
- States and transitions (evaluated only on cycles where FIFO_READ=1; otherwise the state holds):
  - EXP0:
    - Identifier match and index 0: load TS_DATA[23:0], go to EXP1.
    - Identifier match, index not 0: sequence error, stay in EXP0.
    - Identifier mismatch: identifier error, stay in EXP0.
  - EXP1:
    - Identifier match and index 1: load TS_DATA[47:24], go to EXP2.
    - Identifier match and index 0: sequence error; restart with this word by loading [23:0] and staying in EXP1.
    - Any other index: sequence error, go to EXP0.
    - Identifier mismatch: identifier error, go to EXP0.
  - EXP2:
    - Identifier match and index 2: load TS_DATA[63:48], set TS_VALID, go to OUT.
    - Identifier match and index 0: sequence error; restart by loading [23:0] and going to EXP1.
    - Any other index: sequence error, go to EXP0.
    - Identifier mismatch: identifier error, go to EXP0.
  - OUT:
    - TS_VALID=1 and TS_DATA stable until TS_READY=1.
    - On the handshake cycle: clear TS_VALID, increment EVT_CNT, go to EXP0.
- Latency: word 2 popped in cycle N gives TS_VALID=1 in cycle N+1. Throughput is at most one event per 4 cycles.
- TS_DATA bits not yet loaded for the current event keep stale values. Consumers use TS_DATA only while TS_VALID=1.
- ERR_CNT increments by exactly 1 per erroneous word and saturates (no wrap).
- EVT_CNT wraps from all-ones to 0.
- CLR has priority over increments in the same cycle: counters become 0, not 1. CLR does not affect state or TS_VALID.
- An identifier error and a sequence error never count twice for the same word.
- FIFO_EMPTY going high mid-event: wait in the current state indefinitely; no timeout.

Test Plan:
- Reset, then words 0x50ABCDEF, 0x51123456, 0x52FF7788 -> TS_DATA=0x7788_123456_ABCDEF with TS_VALID one cycle after the third pop; with TS_READY=1, EVT_CNT=1.
- Same event with TS_READY=0 for 10 cycles, FIFO non-empty -> FIFO_READ=0 throughout, TS_DATA stable; after READY, the next event decodes correctly.
- Stream 0x50000001, 0x50000002, 0x51000000, 0x52000000 -> one event, TS=0x0000_000000_000002; ERR_CNT=1.
- Word 0x30000000 in EXP1 -> ERR_CNT=1, state EXP0; the following valid 3-word event decodes correctly.
- 300 identifier-mismatch words -> ERR_CNT=255. CLR pulse coincident with an error word -> ERR_CNT=0.
- Assert RST_N=0 asynchronously between word 1 and word 2 -> outputs reset immediately; a fresh event after release decodes with EVT_CNT=1.
